mem_bank_arbiter: RTL
=====================

Name: mem_bank_arbiter

Overview:
- Shares the dual-bank (even/odd byte) memory between two requesters:
  - the CPU instruction-fetch port
  - a data load/store port
- Every 16-bit access, aligned or unaligned, completes in one memory cycle by addressing both banks simultaneously.
- Arbitration is data-priority with a starvation guard for fetch; read responses return one cycle after grant.
- Sits between the cpu core and the banked RAM.

Parameters:
STARVE_MAX, 4, consecutive denied cycles after which a pending fetch is forced to win (range 1..15).

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
if_req  input  1  fetch request; must hold if_addr stable until if_gnt
if_addr  input  16  fetch byte address
if_gnt  output  1  fetch accepted this cycle
if_rvalid  output  1  fetch read data valid (one cycle after if_gnt)
if_rdata  output  16  {byte at A+1, byte at A}
d_req  input  1  data request; hold d_* stable until d_gnt
d_we  input  1  1 = write, 0 = read
d_addr  input  16  data byte address
d_wdata  input  16  write data {hi, lo}
d_wmask  input  2  byte enables: [0] = lo byte (A), [1] = hi byte (A+1)
d_gnt  output  1  data accepted this cycle
d_rvalid  output  1  data read data valid (one cycle after read grant)
d_rdata  output  16  {byte at A+1, byte at A}
mem_read_addr_even  output  15  even-bank read word address
mem_read_data_even  input  8  even-bank read data (synchronous, 1-cycle latency)
mem_write_addr_even  output  15  even-bank write address
mem_write_data_even  output  8  even-bank write data
mem_write_en_even  output  1  even-bank write strobe
mem_read_addr_odd, mem_read_data_odd, mem_write_addr_odd, mem_write_data_odd, mem_write_en_odd: same for odd bank

Behaviour:
- Reset (reset = 0, async):
  - if_gnt, d_gnt, if_rvalid, d_rvalid, mem_write_en_even/odd = 0
  - starve counter = 0; response tag cleared
  - rdata outputs = 0
  - Reads issued but not yet returned are dropped: no rvalid after reset release.
- Address mapping for byte address A, W = A[15:1]:
  - A[0] = 0: lo byte from even[W], hi byte from odd[W].
  - A[0] = 1: lo byte from odd[W], hi byte from even[W+1]. W+1 wraps modulo 2^15, so A = 16'hFFFF takes hi from even[0].
- Arbitration, evaluated combinationally each cycle; at most one grant per cycle:
  - Only d_req: grant data.
  - Only if_req: grant fetch.
  - Both: grant data, unless starve count = STARVE_MAX, in which case grant fetch.
- Starve counter (4 bits, registered):
  - Increments when if_req = 1 and if_gnt = 0.
  - Clears on if_gnt or when if_req = 0.
  - Saturates at STARVE_MAX.
- Idle cycle (no grant):
  - Read addresses driven from if_addr (keeps sequential prefetch warm).
  - No write strobes.
  - No rvalid in the following cycle.
- Read grant: drive both bank read addresses per the mapping. Register the response tag {owner, A[0]} for one cycle.
- Read response, cycle N+1:
  - The owner's rvalid = 1.
  - rdata assembled from the bank outputs using the registered A[0].
  - rdata holds its value until the next response.
- Write grant (d_we = 1):
  - Strobes asserted combinationally in the grant cycle, only for bytes with d_wmask set.
  - mask[0] targets the lo-byte bank; mask[1] targets the hi-byte bank, mapped as above.
  - No rvalid is produced for writes.
  - d_wmask = 2'b00 is granted with no strobes.
- Write followed immediately by a read of the same address returns the new data. The memory is write-before-read; the arbiter adds no forwarding.
- d_gnt and if_gnt are never both 1. Grants may be given in back-to-back cycles.
- Requesters must not change req, addr or data while req = 1 and gnt = 0. Behaviour is undefined if they do.

Optional Feature:
MEM_BANK_ARB_ROUND_ROBIN_EN
- Defined: the starve counter is removed. When both requesters are active, the winner alternates via a 1-bit last-winner register. This register resets to "fetch", so data wins the first contention; it updates only on contended grants.
- Undefined: data-priority with the STARVE_MAX guard, as above.

Test Plan:
- Aligned read: d_req = 1, d_we = 0, d_addr = 16'h4000; even[0x2000] = 8'h12, odd[0x2000] = 8'h34 → d_gnt same cycle; next cycle d_rvalid = 1, d_rdata = 16'h3412.
- Unaligned read with wrap: if_addr = 16'hFFFF; odd[0x7FFF] = 8'hAA, even[0x0000] = 8'hBB → mem_read_addr_odd = 15'h7FFF, mem_read_addr_even = 15'h0000; if_rdata = 16'hBBAA one cycle after grant.
- Masked unaligned write: d_addr = 16'h1001, d_wdata = 16'hBEEF, d_wmask = 2'b10 → only mem_write_en_even = 1, addr 15'h0801, data 8'hBE; mem_write_en_odd = 0.
- Starvation (STARVE_MAX = 4): if_req and d_req held high continuously → d_gnt on cycles 0–3, if_gnt on cycle 4, then d_gnt resumes.
- Reset mid-operation: read granted at cycle N, reset driven low between edges N and N+1 → rvalid stays 0, all strobes 0; after release with no requests, no spurious grant or rvalid.
- With MEM_BANK_ARB_ROUND_ROBIN_EN: both requesting continuously → grants d, if, d, if, …; without the macro → d, d, d, d, if, ….

Source files
------------

// File: rtl/mem_bank_arbiter.sv
// mem_bank_arbiter: shares the even/odd byte-banked RAM between the fetch port and the data load/store port
//
// Every 16-bit access, aligned or not, completes in one memory cycle because both banks are addressed at once.
// Data has priority over fetch. A starvation counter forces a pending fetch to win after STARVE_MAX denied cycles.
// Read data returns one cycle after the grant.
// Defining MEM_BANK_ARB_ROUND_ROBIN_EN replaces the starvation guard with alternating priority on contention.
//
// Ports:
//   clk, reset                 clock (rising edge), asynchronous active-low reset
//   if_req/if_addr             fetch request and byte address
//   if_gnt/if_rvalid/if_rdata  fetch grant, read valid, read data {A+1, A}
//   d_req/d_we/d_addr          data request, write flag and byte address
//   d_wdata/d_wmask            data write data {hi, lo} and byte enables
//   d_gnt/d_rvalid/d_rdata     data grant, read valid, read data {A+1, A}
//   mem_*_even, mem_*_odd      per-bank read address/data and write address/data/strobe
module mem_bank_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [15:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    input  logic [1:0]  d_wmask,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [15:0] d_rdata,
    output logic [14:0] mem_read_addr_even,
    input  logic [7:0]  mem_read_data_even,
    output logic [14:0] mem_write_addr_even,
    output logic [7:0]  mem_write_data_even,
    output logic        mem_write_en_even,
    output logic [14:0] mem_read_addr_odd,
    input  logic [7:0]  mem_read_data_odd,
    output logic [14:0] mem_write_addr_odd,
    output logic [7:0]  mem_write_data_odd,
    output logic        mem_write_en_odd
);
    logic        if_win;
    logic        wr;
    logic [15:0] sel_addr;
    logic [14:0] rw, dw;
    logic        if_pend, d_pend, tag_a0;
    logic [15:0] asm_data, if_hold, d_hold;
`ifdef MEM_BANK_ARB_ROUND_ROBIN_EN
    logic        last_if;
    assign if_win = if_req & (~d_req | ~last_if);
`else
    logic [3:0]  starve;
    assign if_win = if_req & (~d_req | (starve == 4'(STARVE_MAX)));
`endif
    // Grants are suppressed while reset is held so no strobe can fire.
    assign if_gnt = reset & if_win;
    assign d_gnt  = reset & d_req & ~if_win;
    assign wr     = d_gnt & d_we;
    // Idle cycles keep the fetch address on the read ports.
    assign sel_addr = d_gnt ? d_addr : if_addr;
    assign rw       = sel_addr[15:1];
    assign dw       = d_addr[15:1];
    // An odd address takes its high byte from the next even word, wrapping at the top.
    assign mem_read_addr_even  = sel_addr[0] ? rw + 15'd1 : rw;
    assign mem_read_addr_odd   = rw;
    assign mem_write_addr_even = d_addr[0] ? dw + 15'd1 : dw;
    assign mem_write_addr_odd  = dw;
    assign mem_write_data_even = d_addr[0] ? d_wdata[15:8] : d_wdata[7:0];
    assign mem_write_data_odd  = d_addr[0] ? d_wdata[7:0] : d_wdata[15:8];
    assign mem_write_en_even   = wr & (d_addr[0] ? d_wmask[1] : d_wmask[0]);
    assign mem_write_en_odd    = wr & (d_addr[0] ? d_wmask[0] : d_wmask[1]);
    assign asm_data  = tag_a0 ? {mem_read_data_even, mem_read_data_odd}
                              : {mem_read_data_odd, mem_read_data_even};
    assign if_rvalid = if_pend;
    assign d_rvalid  = d_pend;
    assign if_rdata  = if_pend ? asm_data : if_hold;
    assign d_rdata   = d_pend ? asm_data : d_hold;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_pend <= 1'b0;
            d_pend  <= 1'b0;
            tag_a0  <= 1'b0;
            if_hold <= 16'h0;
            d_hold  <= 16'h0;
`ifdef MEM_BANK_ARB_ROUND_ROBIN_EN
            last_if <= 1'b1;
`else
            starve  <= 4'h0;
`endif
        end else begin
            if_pend <= if_gnt;
            d_pend  <= d_gnt & ~d_we;
            tag_a0  <= sel_addr[0];
            if (if_pend) if_hold <= asm_data;
            if (d_pend)  d_hold  <= asm_data;
`ifdef MEM_BANK_ARB_ROUND_ROBIN_EN
            if (if_req && d_req) last_if <= if_gnt;
`else
            starve  <= (if_req && !if_gnt) ? ((starve == 4'(STARVE_MAX)) ? starve : starve + 4'd1) : 4'h0;
`endif
        end
    end
endmodule
